// File: rtl/qos_pkg.sv
// Shared types and widths for the QoS memory-port arbiter.
// Imported by the arbiter top and its winner-selection block.
package qos_pkg;

  localparam int N_REQ  = 4;
  localparam int PRIO_W = 2;
  localparam int CRED_W = 8;
  localparam int WAIT_W = 6;
  localparam int IDX_W  = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_ISSUE  = 2'd2,
    S_WAIT   = 2'd3
  } state_e;

  typedef logic [N_REQ-1:0][CRED_W-1:0] cred_vec_t;
  typedef logic [N_REQ-1:0][WAIT_W-1:0] wait_vec_t;

  function automatic logic [WAIT_W-1:0] wait_inc(
    input logic [WAIT_W-1:0] w
  );
    return (&w) ? w : w + 1'b1;
  endfunction

  function automatic logic [CRED_W-1:0] cred_dec(
    input logic [CRED_W-1:0] c
  );
    return (|c) ? c - 1'b1 : c;
  endfunction

endpackage

// File: rtl/qos_pick.sv
// Winner selection: highest priority among candidates,
// ties resolved round-robin starting at rr_ptr_i.
module qos_pick
  import qos_pkg::*;
(
  input  logic [N_REQ-1:0]        cand_i,
  input  logic [N_REQ*PRIO_W-1:0] prio_i,
  input  logic [IDX_W-1:0]        rr_ptr_i,
  output logic                    any_o,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [IDX_W-1:0]        idx_o
);

  logic [PRIO_W-1:0] top_prio;
  logic [IDX_W-1:0]  j;

  always_comb begin
    top_prio = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (cand_i[i] &&
          prio_i[i*PRIO_W +: PRIO_W] > top_prio) begin
        top_prio = prio_i[i*PRIO_W +: PRIO_W];
      end
    end
  end

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = rr_ptr_i + IDX_W'(k);
      if (!any_o && cand_i[j] &&
          prio_i[j*PRIO_W +: PRIO_W] == top_prio) begin
        any_o = 1'b1;
        idx_o = j;
      end
    end
    gnt_o = any_o ? (N_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/qos_arbiter.sv
// Credit/priority/age arbiter for one shared memory port,
// one outstanding transaction at a time.
module qos_arbiter #(
  parameter int N_REQ     = 4,
  parameter int AGE_LIMIT = 63
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst,
  input  logic [N_REQ-1:0]                  req_valid,
  output logic [N_REQ-1:0]                  req_ready,
  input  logic [qos_pkg::PRIO_W*N_REQ-1:0]  req_prio,
  input  logic [qos_pkg::CRED_W*N_REQ-1:0]  cfg_weight,
  output logic                              mem_valid,
  input  logic                              mem_ready,
  output logic [qos_pkg::IDX_W-1:0]         mem_sel,
  input  logic                              mem_done,
  output logic [N_REQ-1:0]                  grant,
  output logic                              busy
);
  import qos_pkg::*;

  localparam logic [WAIT_W-1:0] AGE_LIM = WAIT_W'(AGE_LIMIT);

  state_e state_q, state_d;

  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  cred_vec_t        credit_q, credit_d;
  wait_vec_t        wait_q, wait_d;

  logic [N_REQ-1:0]        urgent;
  logic [N_REQ-1:0]        eligible;
  logic [N_REQ-1:0]        cand;
  logic [N_REQ*PRIO_W-1:0] pick_prio;
  logic                    pick_any;
  logic [N_REQ-1:0]        pick_gnt;
  logic [IDX_W-1:0]        pick_idx;
  logic                    issue_fire;
  logic                    done_fire;
  logic                    do_pick;

  always_comb begin
    urgent   = '0;
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
      urgent[i]   = req_valid[i] && (wait_q[i] >= AGE_LIM);
      eligible[i] = req_valid[i] && (|credit_q[i]);
    end
  end

  // Aged requesters preempt everything and ignore priority.
  assign cand      = (|urgent) ? urgent : eligible;
  assign pick_prio = (|urgent) ? '0 : req_prio;

  qos_pick u_pick (
    .cand_i   (cand),
    .prio_i   (pick_prio),
    .rr_ptr_i (rr_q),
    .any_o    (pick_any),
    .gnt_o    (pick_gnt),
    .idx_o    (pick_idx)
  );

  assign issue_fire = (state_q == S_ISSUE) && mem_ready;
  assign done_fire  = (state_q == S_WAIT) && mem_done;
  assign do_pick    = (state_q == S_IDLE) && pick_any;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          state_d = S_ISSUE;
        end else if (|req_valid) begin
          state_d = S_REFILL;
        end
      end
      S_REFILL: state_d = S_IDLE;
      S_ISSUE: begin
        if (mem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_valid = (state_q == S_ISSUE);
    req_ready = issue_fire ? grant_q : '0;
    busy      = (state_q != S_IDLE);
    grant     = grant_q;
    mem_sel   = sel_q;
  end

  always_comb begin
    grant_d  = grant_q;
    sel_d    = sel_q;
    rr_d     = rr_q;
    credit_d = credit_q;
    wait_d   = wait_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && !grant_q[i]) begin
        wait_d[i] = wait_inc(wait_q[i]);
      end
    end
    if (do_pick) begin
      grant_d = pick_gnt;
      sel_d   = pick_idx;
    end
    if (state_q == S_REFILL) begin
      credit_d = cfg_weight;
    end
    if (done_fire) begin
      credit_d[sel_q] = cred_dec(credit_q[sel_q]);
      wait_d[sel_q]   = '0;
      rr_d            = sel_q + 1'b1;
      grant_d         = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      grant_q  <= '0;
      sel_q    <= '0;
      rr_q     <= '0;
      wait_q   <= '0;
      credit_q <= cfg_weight;
    end else begin
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      rr_q     <= rr_d;
      wait_q   <= wait_d;
      credit_q <= credit_d;
    end
  end

endmodule

// File: tb/tb_qos_arbiter.sv
// Scoreboard bench for qos_arbiter: expected grant order
// is queued per scenario and popped as the DUT issues.
module tb_qos_arbiter;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [7:0]  req_prio = '0;
  logic [31:0] cfg_weight = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b1;
  logic [1:0]  mem_sel;
  logic        mem_done = 1'b0;
  logic [3:0]  grant;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int sb[$];
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  qos_arbiter #(.N_REQ(4), .AGE_LIMIT(63)) dut (
    .sys_clk    (clk),
    .sys_rst    (sys_rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_prio   (req_prio),
    .cfg_weight (cfg_weight),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_sel    (mem_sel),
    .mem_done   (mem_done),
    .grant      (grant),
    .busy       (busy)
  );

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!$onehot0(grant) || (!busy && grant !== 4'b0)) begin
        failures++;
        $display("FAIL grant_onehot: got grant=%b busy=%b want onehot0, zero when idle",
                 grant, busy);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    sys_rst = 1'b1;
    repeat (2) @(negedge clk);
    sys_rst = 1'b0;
  endtask

  task automatic run_grants(input int n, input int dly, input bit strict);
    int cnt;
    int e;
    for (int g = 0; g < n; g++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!mem_valid && cnt < 400);
      checks++;
      if (!mem_valid) begin
        failures++;
        $display("FAIL issue_timeout: got mem_valid=0 want 1 (grant %0d)", g);
        return;
      end
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow: got grant=%b want none", grant);
        e = 0;
      end else begin
        e = sb.pop_front();
        if (mem_sel !== e[1:0] || grant !== (4'b1 << e)) begin
          failures++;
          $display("FAIL grant_order: got sel=%0d grant=%b want sel=%0d", mem_sel, grant, e);
        end
      end
      if (strict) begin
        checks++;
        if (cnt != 1) begin
          failures++;
          $display("FAIL issue_latency: got %0d want 1 cycles", cnt);
        end
      end
      checks++;
      if (req_ready !== grant) begin
        failures++;
        $display("FAIL ready_pulse: got %b want %b", req_ready, grant);
      end
      repeat (dly) @(negedge clk);
      mem_done = 1'b1;
      @(negedge clk);
      mem_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    cfg_weight = {4{8'd5}};
    req_prio = '0;
    req_valid = '0;
    mem_ready = 1'b1;
    do_reset();
    mon_en = 1'b1;
    checks++;
    if (grant !== 4'b0) begin
      failures++;
      $display("FAIL rst_grant: got %b want 0000", grant);
    end
    checks++;
    if (req_ready !== 4'b0) begin
      failures++;
      $display("FAIL rst_ready: got %b want 0000", req_ready);
    end
    checks++;
    if (mem_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_valid_busy: got %b%b want 00", mem_valid, busy);
    end
    checks++;
    if (mem_sel !== 2'd0) begin
      failures++;
      $display("FAIL rst_sel: got %0d want 0", mem_sel);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_round_robin();
    cfg_weight = {4{8'd2}};
    req_prio = '0;
    req_valid = 4'hF;
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) sb.push_back(i);
    run_grants(8, 2, 1'b1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || grant !== 4'b0 || mem_valid !== 1'b0) begin
      failures++;
      $display("FAIL refill_cycle: got busy=%b grant=%b mv=%b want 1 0000 0",
               busy, grant, mem_valid);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_priority();
    cfg_weight = {8'd0, 8'd3, 8'd0, 8'd3};
    req_prio = {2'd0, 2'd3, 2'd0, 2'd1};
    req_valid = 4'b0101;
    do_reset();
    sb.push_back(2);
    sb.push_back(2);
    sb.push_back(2);
    sb.push_back(0);
    run_grants(4, 2, 1'b1);
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_aging();
    cfg_weight = {4{8'd255}};
    req_prio = {2'd3, 2'd0, 2'd0, 2'd0};
    req_valid = 4'b1010;
    do_reset();
    sb.push_back(3);
    sb.push_back(3);
    sb.push_back(3);
    sb.push_back(1);
    run_grants(4, 20, 1'b1);
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int pulses;
    int e;
    cfg_weight = {4{8'd4}};
    req_prio = '0;
    mem_ready = 1'b0;
    req_valid = '0;
    do_reset();
    req_valid = 4'b0001;
    sb.push_back(0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (mem_valid !== 1'b1 || grant !== 4'b0001 || req_ready !== 4'b0) begin
        failures++;
        $display("FAIL stall_%0d: got mv=%b grant=%b rdy=%b want 1 0001 0000",
                 c, mem_valid, grant, req_ready);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (req_ready !== 4'b0) begin
        pulses++;
        e = (sb.size() != 0) ? sb.pop_front() : 7;
        checks++;
        if (req_ready !== (4'b1 << e)) begin
          failures++;
          $display("FAIL stall_ready: got %b want idx %0d", req_ready, e);
        end
        req_valid = '0;
      end
      @(negedge clk);
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL stall_pulses: got %0d want 1", pulses);
    end
    mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_done: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_in_wait();
    int e;
    cfg_weight = {4{8'd1}};
    req_prio = '0;
    mem_ready = 1'b1;
    req_valid = 4'b0010;
    do_reset();
    sb.push_back(1);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (grant !== (4'b1 << e)) begin
      failures++;
      $display("FAIL rw_grant: got %b want idx %0d", grant, e);
    end
    @(negedge clk);
    sys_rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    sys_rst = 1'b0;
    checks++;
    if (grant !== 4'b0 || busy !== 1'b0 || mem_valid !== 1'b0) begin
      failures++;
      $display("FAIL rw_abandon: got grant=%b busy=%b mv=%b want 0000 0 0",
               grant, busy, mem_valid);
    end
    mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rw_stray_done: got busy=%b want 0", busy);
    end
    req_valid = 4'hF;
    sb.push_back(0);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (grant !== (4'b1 << e) || mem_sel !== e[1:0]) begin
      failures++;
      $display("FAIL rw_state_kept: got grant=%b sel=%0d want idx %0d", grant, mem_sel, e);
    end
    req_valid = '0;
    @(negedge clk);
    mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0;
  endtask

  task automatic test_zero_weight();
    int cnt;
    int e;
    cfg_weight = '0;
    req_prio = '0;
    mem_ready = 1'b1;
    req_valid = 4'b0001;
    do_reset();
    sb.push_back(0);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        checks++;
        if (busy !== 1'b1 || grant !== 4'b0) begin
          failures++;
          $display("FAIL zw_refill: got busy=%b grant=%b want 1 0000", busy, grant);
        end
      end
    end while (!mem_valid && cnt < 200);
    e = sb.pop_front();
    checks++;
    if (grant !== (4'b1 << e)) begin
      failures++;
      $display("FAIL zw_grant: got %b want idx %0d", grant, e);
    end
    checks++;
    if (cnt != 65) begin
      failures++;
      $display("FAIL zw_age_cycles: got %0d want 65", cnt);
    end
    req_valid = '0;
    @(negedge clk);
    mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_priority();
    test_aging();
    test_backpressure();
    test_reset_in_wait();
    test_zero_weight();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d want 0 entries", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
